// File: rtl/wptr_full_level.sv
// Write-domain pointer and status block for the asynchronous FIFO.
// Produces the RAM write address, the Gray write pointer that crosses to the
// read domain, and registered level / full / almost-full / overflow status
// derived from the synchronised read pointer.
module wptr_full_level #(
    parameter int ADDR_SIZE = 4
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic                 winc,
    input  logic [ADDR_SIZE:0]   wq2_rptr,
    input  logic [ADDR_SIZE:0]   waf_thresh,
    input  logic                 wovf_clr,
    output logic [ADDR_SIZE-1:0] waddr,
    output logic [ADDR_SIZE:0]   wptr,
    output logic                 wfull,
    output logic                 walmost_full,
    output logic [ADDR_SIZE:0]   wlevel,
    output logic                 woverflow
);

    localparam logic [ADDR_SIZE:0] DEPTH = (ADDR_SIZE+1)'(1) << ADDR_SIZE;

    logic [ADDR_SIZE:0] wbin_reg;
    logic [ADDR_SIZE:0] wbin_next;
    logic [ADDR_SIZE:0] wgray_next;
    logic [ADDR_SIZE:0] rbin_s;
    logic [ADDR_SIZE:0] level_next;
    logic               wpush;
    logic               full_next;
    logic               almost_full_next;

    // Gray-to-binary of the synchronised read pointer: each binary bit is the
    // XOR of all Gray bits at or above it (prefix XOR from the MSB down).
    generate
        for (genvar gi = 0; gi <= ADDR_SIZE; gi++) begin : g_gray2bin
            assign rbin_s[gi] = ^(wq2_rptr >> gi);
        end
    endgenerate

    // Next-pointer, level and flag evaluation; the push is gated by the
    // registered full flag so a write in the cycle full drops is still refused.
    always_comb begin
        wpush            = winc & ~wfull;
        wbin_next        = wbin_reg + {{ADDR_SIZE{1'b0}}, wpush};
        wgray_next       = wbin_next ^ (wbin_next >> 1);
        level_next       = wbin_next - rbin_s;
        // Level equal to DEPTH is exactly the Gray test "top two bits differ,
        // rest equal", since both pointers come from the same modular count.
        full_next        = (level_next == DEPTH);
        almost_full_next = (level_next >= waf_thresh);
    end

    // Pointer and status registers, all updated together on each write edge.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_reg     <= '0;
            wptr         <= '0;
            wlevel       <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
        end else begin
            wbin_reg     <= wbin_next;
            wptr         <= wgray_next;
            wlevel       <= level_next;
            wfull        <= full_next;
            walmost_full <= almost_full_next;
        end
    end

    // Sticky overflow: a refused write sets it, and setting wins over clearing.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            woverflow <= 1'b0;
        end else if (winc && wfull) begin
            woverflow <= 1'b1;
        end else if (wovf_clr) begin
            woverflow <= 1'b0;
        end
    end

    assign waddr = wbin_reg[ADDR_SIZE-1:0];

endmodule

// File: tb/tb_wptr_full_level.sv
// Bench for wptr_full_level: a count-based model (words written, reads seen)
// predicts every registered output, with randomized streaming traffic.
module tb_wptr_full_level;

    logic       wclk;
    logic       wrst_n;
    logic       winc;
    logic [4:0] wq2_rptr;
    logic [4:0] waf_thresh;
    logic       wovf_clr;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       woverflow;

    wptr_full_level #(.ADDR_SIZE(4)) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .waf_thresh   (waf_thresh),
        .wovf_clr     (wovf_clr),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: total words accepted, total reads visible, flags.
    int m_wr  = 0;
    int m_rd  = 0;
    int m_level = 0;
    bit m_full = 0;
    bit m_af   = 0;
    bit m_ovf  = 0;

    function automatic logic [4:0] gray5(input int n);
        logic [4:0] b;
        b = n[4:0];
        return b ^ (b >> 1);
    endfunction

    function automatic logic [16:0] model_vec();
        int wa;
        wa = m_wr % 16;
        return {wa[3:0], gray5(m_wr % 32), m_level[4:0], m_full, m_af, m_ovf};
    endfunction

    task automatic set_rd(input int n);
        m_rd = n;
        wq2_rptr = gray5(n % 32);
    endtask

    // One clock edge with the currently driven inputs; model updated after it.
    task automatic clk_step();
        bit acc;
        bit setv;
        acc  = winc && !m_full;
        setv = winc && m_full;
        @(posedge wclk);
        #1;
        if (acc) m_wr++;
        m_level = m_wr - m_rd;
        m_full  = (m_level == 16);
        m_af    = (m_level >= int'(waf_thresh));
        m_ovf   = setv ? 1'b1 : (wovf_clr ? 1'b0 : m_ovf);
    endtask

    task automatic test_reset();
        logic [16:0] obs;
        wrst_n = 1'b0; winc = 1'b0; wovf_clr = 1'b0; waf_thresh = 5'd12;
        set_rd(0);
        #2;
        obs = {waddr, wptr, wlevel, wfull, walmost_full, woverflow};
        total_cnt++;
        if (obs !== 17'd0) $display("FAIL reset_hold: got %h expected 0", obs);
        else pass_cnt++;
        @(negedge wclk);
        wrst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            clk_step();
            obs = {waddr, wptr, wlevel, wfull, walmost_full, woverflow};
            total_cnt++;
            if (obs !== 17'd0 || obs !== model_vec())
                $display("FAIL reset_idle[%0d]: got %h expected 0 (model %h)", i, obs, model_vec());
            else pass_cnt++;
        end
        $display("reset: done");
    endtask

    task automatic test_fill();
        logic [16:0] obs;
        winc = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            clk_step();
            obs = {waddr, wptr, wlevel, wfull, walmost_full, woverflow};
            total_cnt++;
            if (obs !== model_vec() || wlevel !== 5'(i))
                $display("FAIL fill[%0d]: got %h expected %h", i, obs, model_vec());
            else pass_cnt++;
            $display("fill write %0d: wlevel=%0d af=%0b full=%0b", i, wlevel, walmost_full, wfull);
        end
        total_cnt++;
        if (wptr !== 5'b11000 || waddr !== 4'd0)
            $display("FAIL fill_end: wptr=%b waddr=%0d expected 11000/0", wptr, waddr);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [16:0] obs;
        winc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clk_step();
            obs = {waddr, wptr, wlevel, wfull, walmost_full, woverflow};
            total_cnt++;
            if (obs !== model_vec() || woverflow !== 1'b1 || wlevel !== 5'd16)
                $display("FAIL ovf_reject[%0d]: got %h expected %h", i, obs, model_vec());
            else pass_cnt++;
        end
        winc = 1'b0; wovf_clr = 1'b1;
        clk_step();
        total_cnt++;
        if (woverflow !== m_ovf || woverflow !== 1'b0)
            $display("FAIL ovf_clear: got %b expected 0", woverflow);
        else pass_cnt++;
        winc = 1'b1;
        clk_step();
        total_cnt++;
        if (woverflow !== m_ovf || woverflow !== 1'b1)
            $display("FAIL ovf_set_priority: got %b expected 1", woverflow);
        else pass_cnt++;
        winc = 1'b0; wovf_clr = 1'b0;
        $display("overflow: done");
    endtask

    task automatic test_release();
        set_rd(1);
        clk_step();
        total_cnt++;
        if (wfull !== 1'b0 || wlevel !== 5'd15 || walmost_full !== 1'b1)
            $display("FAIL full_release: full=%b level=%0d af=%b expected 0/15/1", wfull, wlevel, walmost_full);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        int hist[$];
        int start;
        int cycles;
        logic [4:0] prev;
        logic [16:0] obs;
        waf_thresh = 5'($urandom_range(0, 16));
        start = m_wr;
        cycles = 0;
        prev = wptr;
        while (m_wr < start + 100 && cycles < 400) begin
            hist.push_back(m_wr);
            if (hist.size() > 2) set_rd(hist.pop_front());
            winc = ($urandom_range(0, 9) != 0);
            clk_step();
            cycles++;
            obs = {waddr, wptr, wlevel, wfull, walmost_full, woverflow};
            total_cnt++;
            if (obs !== model_vec() || $countones(wptr ^ prev) > 1)
                $display("FAIL stream[%0d]: got %h expected %h prev_wptr %b", cycles, obs, model_vec(), prev);
            else pass_cnt++;
            prev = wptr;
        end
        total_cnt++;
        if (m_wr < start + 100) $display("FAIL stream_timeout: wrote %0d required 100", m_wr - start);
        else pass_cnt++;
        $display("stream: %0d writes in %0d cycles, thresh=%0d", m_wr - start, cycles, waf_thresh);
    endtask

    task automatic test_reset_mid();
        logic [16:0] obs;
        winc = 1'b0;
        set_rd(m_wr - 9);
        clk_step();
        total_cnt++;
        if (wlevel !== 5'd9 || wlevel !== m_level[4:0])
            $display("FAIL pre_reset_level: got %0d expected 9", wlevel);
        else pass_cnt++;
        #2;
        wrst_n = 1'b0;
        #1;
        obs = {waddr, wptr, wlevel, wfull, walmost_full, woverflow};
        total_cnt++;
        if (obs !== 17'd0) $display("FAIL async_reset: got %h expected 0", obs);
        else pass_cnt++;
        m_wr = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
        set_rd(0);
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    task automatic test_thresh_edges();
        waf_thresh = 5'd0;
        clk_step();
        total_cnt++;
        if (walmost_full !== 1'b1 || walmost_full !== m_af)
            $display("FAIL thresh_zero: got %b expected 1", walmost_full);
        else pass_cnt++;
        waf_thresh = 5'd16; winc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            clk_step();
            total_cnt++;
            if (walmost_full !== wfull || walmost_full !== m_af || wfull !== m_full)
                $display("FAIL thresh_depth[%0d]: af=%b full=%b expected %b/%b", i, walmost_full, wfull, m_af, m_full);
            else pass_cnt++;
        end
        winc = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_release();
        test_stream();
        test_reset_mid();
        test_thresh_edges();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
